// File: rtl/key_encoder_8to3.sv
// key_encoder_8to3
//   Debounced 8-to-3 priority encoder for active-low keys/switches. The
//   highest-index asserted line is reported as a 3-bit code. valid stays
//   high while a debounced key is held, and single-cycle press/release
//   pulses mark acceptance and release of that key. The block is active
//   only while enable == 3'd4.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable cycles needed to accept a press
//                     or a release (>= 1)
//   CNT_W           - debounce counter width (2**CNT_W > DEBOUNCE_CYCLES)
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   enable  [2:0] in   block active only when equal to 3'd4
//   keys    [7:0] in   active-low key lines, bit 7 has highest priority
//   code    [2:0] out  registered index of the accepted key
//   valid         out  high while a debounced key is held
//   press         out  one-cycle pulse when a key is accepted
//   release_pulse out  one-cycle pulse when the held key is released
//                      ("release" is a reserved word in SystemVerilog)
//
// Build option:
//   KEY_ENC_SYNC_EN - when defined, keys pass through a two-flop
//                     synchronizer before sampling (+1 cycle latency).

module key_encoder_8to3 #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] enable,
    input  logic [7:0] keys,
    output logic [2:0] code,
    output logic       valid,
    output logic       press,
    output logic       release_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE_DB
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       cand, cand_nxt;
    logic [2:0]       code_nxt;
    logic             valid_nxt, press_nxt, release_nxt;
    logic [7:0]       samp;
    logic             raw_any;
    logic [2:0]       raw_code;

`ifdef KEY_ENC_SYNC_EN
    // samp doubles as the second synchronizer stage, so only one extra
    // flop is added in front of it.
    logic [7:0] sync1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            samp  <= '1;
        end else begin
            sync1 <= keys;
            samp  <= sync1;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp <= '1;
        end else begin
            samp <= keys;
        end
    end
`endif

    // Ascending scan: the last (highest) zero bit found wins.
    always_comb begin
        raw_any  = ~&samp;
        raw_code = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!samp[i]) begin
                raw_code = 3'(i);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cand_nxt    = cand;
        code_nxt    = code;
        valid_nxt   = valid;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;

        if (enable != 3'd4) begin
            // Disabling drops a held key silently: no release pulse.
            state_nxt = IDLE;
            code_nxt  = '0;
            valid_nxt = 1'b0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (raw_any) begin
                        cand_nxt  = raw_code;
                        cnt_nxt   = '0;
                        state_nxt = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!raw_any) begin
                        state_nxt = IDLE;
                    end else if (raw_code != cand) begin
                        cand_nxt = raw_code;
                        cnt_nxt  = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = HELD;
                        code_nxt  = cand;
                        valid_nxt = 1'b1;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    // A different (e.g. higher-priority) key counts as a
                    // release; the new key is debounced again from IDLE.
                    if (!raw_any || raw_code != code) begin
                        cnt_nxt   = '0;
                        state_nxt = RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (raw_any && raw_code == code) begin
                        state_nxt = HELD;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt   = IDLE;
                        valid_nxt   = 1'b0;
                        release_nxt = 1'b1;
                        code_nxt    = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            cand          <= '0;
            code          <= '0;
            valid         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            cand          <= cand_nxt;
            code          <= code_nxt;
            valid         <= valid_nxt;
            press         <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

endmodule
